vec_execute_pipe: RTL and testbench

Parametrised, pipelined successor of the single-cycle scalar/vector execute stage. It applies per-operand forwarding, scalar-broadcast and immediate operand selection, then issues one scalar op and one LANES-wide vector op per transaction. Results are registered behind a valid/ready handshake. A multi-cycle iterative multiply mode stalls the input side. It sits between decode/register-read and the memory stage.

---
 rtl/vec_execute_pipe.sv | 273 +++++++++++++++++++++++++++
 tb/tb_vec_execute_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_execute_pipe.sv
// Pipelined scalar + LANES-wide vector execute stage with operand forwarding,
// registered valid/ready output and an iterative shift-add multiplier.
module vec_execute_pipe #(
    parameter int LANE_W     = 32,
    parameter int LANES      = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                alu_op,
    input  logic                      op_a_fwd,
    input  logic                      op_b_fwd,
    input  logic [1:0]                sel_a,
    input  logic [1:0]                sel_b,
    input  logic                      vec_a_sel,
    input  logic                      vec_b_sel,
    input  logic [LANES-1:0]          lane_mask,
    input  logic [LANE_W-1:0]         op_a,
    input  logic [LANE_W-1:0]         op_b,
    input  logic [LANE_W-1:0]         imm,
    input  logic [LANE_W-1:0]         fwd_a,
    input  logic [LANE_W-1:0]         fwd_b,
    input  logic [LANES*LANE_W-1:0]   op_av,
    input  logic [LANES*LANE_W-1:0]   op_bv,
    input  logic [LANES*LANE_W-1:0]   fwd_av,
    input  logic [LANES*LANE_W-1:0]   fwd_bv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W-1:0]         result,
    output logic [LANES*LANE_W-1:0]   vresult,
    output logic                      zero,
    output logic                      negative,
    output logic                      carry,
    output logic                      overflow,
    output logic                      eq,
    output logic                      blt,
    output logic                      busy
);
    localparam int SH_W  = $clog2(LANE_W);
    localparam int STEPS = MUL_CYCLES - 1;
    localparam int BPS   = (LANE_W + STEPS - 1) / STEPS;   // multiplier bits retired per cycle
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_VALID = 2'd2} state_t;

    function automatic logic [LANE_W-1:0] lane_alu(input logic [2:0] op,
                                                    input logic [LANE_W-1:0] a,
                                                    input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = a << b[SH_W-1:0];
            3'b110:  r = a >> b[SH_W-1:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] mul_step(input logic [LANE_W-1:0] acc,
                                                    input logic [LANE_W-1:0] a,
                                                    input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] sum;
        sum = acc;
        for (int k = 0; k < BPS; k++) begin
            if (b[k]) sum = sum + (a << k);
            else      sum = sum;
        end
        return sum;
    endfunction

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LANES:0][LANE_W-1:0]  ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
    logic [LANES-1:0]            mask_q, mask_d;
    logic                        eq_p_q, eq_p_d, blt_p_q, blt_p_d;
    logic [LANE_W-1:0]           res_q, res_d;
    logic [LANES*LANE_W-1:0]     vres_q, vres_d;
    logic                        zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic                        ovf_q, ovf_d, eq_q, eq_d, blt_q, blt_d;

    logic [LANE_W-1:0]           a_reg_s, b_reg_s, a_s, b_s;
    logic [LANES*LANE_W-1:0]     av_reg_s, bv_reg_s;
    logic [LANES:0][LANE_W-1:0]  opa_s, opb_s, alu_s, acc_step_s;  // index LANES is the scalar
    logic                        in_fire_s, is_mul_s, mul_last_s, ovf_s, carry_s;

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready);
    assign in_fire_s  = in_valid && in_ready;
    assign is_mul_s   = (alu_op == 3'b111);
    assign mul_last_s = (state_q == ST_MUL) && (cnt_q == CNT_W'(1));
    assign out_valid  = (state_q == ST_VALID);
    assign busy       = (state_q == ST_MUL);
    assign result     = res_q;
    assign vresult    = vres_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign carry      = carry_q;
    assign overflow   = ovf_q;
    assign eq         = eq_q;
    assign blt        = blt_q;

    // Operand selection: forwarding first, then scalar select / vector broadcast.
    // A broadcast lane takes the forward-muxed register value, never the immediate.
    always_comb begin
        a_reg_s  = op_a_fwd ? fwd_a  : op_a;
        b_reg_s  = op_b_fwd ? fwd_b  : op_b;
        av_reg_s = op_a_fwd ? fwd_av : op_av;
        bv_reg_s = op_b_fwd ? fwd_bv : op_bv;
        case (sel_a)
            2'd0:    a_s = a_reg_s;
            2'd1:    a_s = LANE_W'(a_reg_s[15:0]);
            default: a_s = '0;
        endcase
        case (sel_b)
            2'd0:    b_s = b_reg_s;
            2'd1:    b_s = imm;
            default: b_s = '0;
        endcase
        for (int l = 0; l < LANES; l++) begin
            opa_s[l] = vec_a_sel ? av_reg_s[l*LANE_W +: LANE_W] : a_reg_s;
            opb_s[l] = vec_b_sel ? bv_reg_s[l*LANE_W +: LANE_W] : b_reg_s;
        end
        opa_s[LANES] = a_s;
        opb_s[LANES] = b_s;
    end

    // Single-cycle ALU, one multiplier step per lane, and scalar carry/overflow.
    always_comb begin
        for (int l = 0; l <= LANES; l++) begin
            alu_s[l]      = lane_alu(alu_op, opa_s[l], opb_s[l]);
            acc_step_s[l] = mul_step(acc_q[l], ma_q[l], mb_q[l]);
        end
        case (alu_op)
            3'b000: begin
                carry_s = (alu_s[LANES] < a_s);
                ovf_s   = (a_s[LANE_W-1] == b_s[LANE_W-1]) && (alu_s[LANES][LANE_W-1] != a_s[LANE_W-1]);
            end
            3'b001: begin
                carry_s = (a_s >= b_s);
                ovf_s   = (a_s[LANE_W-1] != b_s[LANE_W-1]) && (alu_s[LANES][LANE_W-1] != a_s[LANE_W-1]);
            end
            default: begin
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // Control: IDLE -> VALID (latency 1) or IDLE/VALID -> MUL -> VALID.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire_s) state_d = is_mul_s ? ST_MUL : ST_VALID;
                else           state_d = ST_IDLE;
            end
            ST_MUL: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_VALID;
                else                    state_d = ST_MUL;
            end
            ST_VALID: begin
                if (out_ready && in_valid) state_d = is_mul_s ? ST_MUL : ST_VALID;
                else if (out_ready)        state_d = ST_IDLE;
                else                       state_d = ST_VALID;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: load multiplier, write ALU result, or iterate/finish MUL.
    always_comb begin
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        eq_p_d  = eq_p_q;
        blt_p_d = blt_p_q;
        res_d   = res_q;
        vres_d  = vres_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        eq_d    = eq_q;
        blt_d   = blt_q;
        if (in_fire_s && is_mul_s) begin
            ma_d    = opa_s;
            mb_d    = opb_s;
            acc_d   = '0;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
            mask_d  = lane_mask;
            eq_p_d  = (a_s == b_s);
            blt_p_d = ($signed(a_s) < $signed(b_s));
        end else if (in_fire_s) begin
            res_d   = alu_s[LANES];
            zero_d  = (alu_s[LANES] == '0);
            neg_d   = alu_s[LANES][LANE_W-1];
            carry_d = carry_s;
            ovf_d   = ovf_s;
            eq_d    = (a_s == b_s);
            blt_d   = ($signed(a_s) < $signed(b_s));
            for (int l = 0; l < LANES; l++)
                vres_d[l*LANE_W +: LANE_W] = lane_mask[l] ? alu_s[l] : '0;
        end else if (state_q == ST_MUL) begin
            acc_d = acc_step_s;
            for (int l = 0; l <= LANES; l++) begin
                ma_d[l] = ma_q[l] << BPS;
                mb_d[l] = mb_q[l] >> BPS;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (mul_last_s) begin
                res_d   = acc_step_s[LANES];
                zero_d  = (acc_step_s[LANES] == '0);
                neg_d   = acc_step_s[LANES][LANE_W-1];
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                eq_d    = eq_p_q;
                blt_d   = blt_p_q;
                for (int l = 0; l < LANES; l++)
                    vres_d[l*LANE_W +: LANE_W] = mask_q[l] ? acc_step_s[l] : '0;
            end else begin
                res_d = res_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and result registers; reset discards any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            eq_p_q  <= 1'b0;
            blt_p_q <= 1'b0;
            res_q   <= '0;
            vres_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            eq_q    <= 1'b0;
            blt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            eq_p_q  <= eq_p_d;
            blt_p_q <= blt_p_d;
            res_q   <= res_d;
            vres_q  <= vres_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            eq_q    <= eq_d;
            blt_q   <= blt_d;
        end
    end
endmodule

// File: tb/tb_vec_execute_pipe.sv
// Scoreboard bench for vec_execute_pipe: a driver pushes model-predicted
// results on each input transfer, a monitor pops them on each output transfer.
module tb_vec_execute_pipe;
    localparam int W = 32;
    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, in_ready, op_a_fwd, op_b_fwd, vec_a_sel, vec_b_sel;
    logic out_valid, out_ready, zero, negative, carry, overflow, eq, blt, busy;
    logic [2:0] alu_op;
    logic [1:0] sel_a, sel_b;
    logic [L-1:0] lane_mask;
    logic [W-1:0] op_a, op_b, imm, fwd_a, fwd_b, result;
    logic [L*W-1:0] op_av, op_bv, fwd_av, fwd_bv, vresult;

    vec_execute_pipe #(.LANE_W(W), .LANES(L), .MUL_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op_a_fwd(op_a_fwd), .op_b_fwd(op_b_fwd),
        .sel_a(sel_a), .sel_b(sel_b), .vec_a_sel(vec_a_sel), .vec_b_sel(vec_b_sel),
        .lane_mask(lane_mask), .op_a(op_a), .op_b(op_b), .imm(imm),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .op_av(op_av), .op_bv(op_bv),
        .fwd_av(fwd_av), .fwd_bv(fwd_bv), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .vresult(vresult), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .eq(eq), .blt(blt), .busy(busy));

    typedef struct {
        logic [2:0] op; logic afwd, bfwd; logic [1:0] sela, selb; logic vas, vbs;
        logic [L-1:0] mask; logic [W-1:0] a, b, imm, fa, fb; logic [L*W-1:0] av, bv, fav, fbv;
    } op_t;
    typedef struct { logic [W-1:0] res; logic [L*W-1:0] vres; logic [5:0] flags; } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_err = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << (b % 32);
            3'd6: return a >> (b % 32);
            default: return p[31:0];
        endcase
    endfunction

    function automatic exp_t model(input op_t t);
        exp_t e;
        logic [W-1:0] ra, rb, sa, sb, la, lb;
        logic c, v;
        longint s;
        ra = t.afwd ? t.fa : t.a;
        rb = t.bfwd ? t.fb : t.b;
        sa = (t.sela == 2'd0) ? ra : (t.sela == 2'd1) ? {16'h0, ra[15:0]} : 32'd0;
        sb = (t.selb == 2'd0) ? rb : (t.selb == 2'd1) ? t.imm : 32'd0;
        e.res = calc(t.op, sa, sb);
        c = 1'b0;
        v = 1'b0;
        if (t.op == 3'd0) begin
            c = ({32'd0, sa} + {32'd0, sb}) > 64'hFFFF_FFFF;
            s = longint'($signed(sa)) + longint'($signed(sb));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (t.op == 3'd1) begin
            c = (sa >= sb);
            s = longint'($signed(sa)) - longint'($signed(sb));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        e.flags = {e.res == 32'd0, e.res[31], c, v, sa == sb, $signed(sa) < $signed(sb)};
        for (int l = 0; l < L; l++) begin
            la = t.vas ? (t.afwd ? t.fav[l*W +: W] : t.av[l*W +: W]) : ra;
            lb = t.vbs ? (t.bfwd ? t.fbv[l*W +: W] : t.bv[l*W +: W]) : rb;
            e.vres[l*W +: W] = t.mask[l] ? calc(t.op, la, lb) : 32'd0;
        end
        return e;
    endfunction

    function automatic op_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_t t;
        t.op = op; t.afwd = 1'b0; t.bfwd = 1'b0; t.sela = 2'd0; t.selb = 2'd0;
        t.vas = 1'b1; t.vbs = 1'b1; t.mask = 4'hF; t.a = a; t.b = b; t.imm = 32'd0;
        t.fa = 32'd0; t.fb = 32'd0; t.av = '0; t.bv = '0; t.fav = '0; t.fbv = '0;
        return t;
    endfunction

    function automatic op_t rand_op();
        op_t t;
        t.op = 3'($urandom_range(0, 7)); t.afwd = 1'($urandom); t.bfwd = 1'($urandom);
        t.sela = 2'($urandom); t.selb = 2'($urandom); t.vas = 1'($urandom); t.vbs = 1'($urandom);
        t.mask = 4'($urandom); t.a = $urandom; t.b = ($urandom_range(0, 7) == 0) ? t.a : $urandom;
        t.imm = $urandom; t.fa = $urandom; t.fb = $urandom;
        t.av = {$urandom, $urandom, $urandom, $urandom}; t.bv = {$urandom, $urandom, $urandom, $urandom};
        t.fav = {$urandom, $urandom, $urandom, $urandom}; t.fbv = {$urandom, $urandom, $urandom, $urandom};
        return t;
    endfunction

    task automatic drive(input op_t t);
        alu_op = t.op; op_a_fwd = t.afwd; op_b_fwd = t.bfwd; sel_a = t.sela; sel_b = t.selb;
        vec_a_sel = t.vas; vec_b_sel = t.vbs; lane_mask = t.mask; op_a = t.a; op_b = t.b;
        imm = t.imm; fwd_a = t.fa; fwd_b = t.fb; op_av = t.av; op_bv = t.bv;
        fwd_av = t.fav; fwd_bv = t.fbv;
    endtask

    // Called just after a rising edge; returns just after the edge that took the op.
    task automatic send_op(input op_t t, output int waits);
        drive(t);
        in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(t));
                break;
            end
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 128'(waits), 128'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    exp_t mon_e;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_res;
    logic [L*W-1:0] prev_vres;
    logic [5:0] prev_flags;

    // Output monitor: scoreboard compare on transfer, stability check under backpressure.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 128'(out_valid), 128'd1);
                chk("hold_result", 128'(result), 128'(prev_res));
                chk("hold_vresult", 128'(vresult), 128'(prev_vres));
                chk("hold_flags", 128'({zero, negative, carry, overflow, eq, blt}), 128'(prev_flags));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 128'(out_valid), 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", 128'(result), 128'(mon_e.res));
                    chk("vresult", 128'(vresult), 128'(mon_e.vres));
                    chk("flags_zncveb", 128'({zero, negative, carry, overflow, eq, blt}), 128'(mon_e.flags));
                end
            end
        end
        prev_stall <= rst_n && out_valid && !out_ready;
        prev_res   <= result;
        prev_vres  <= vresult;
        prev_flags <= {zero, negative, carry, overflow, eq, blt};
    end

    initial begin
        op_t t, t2;
        exp_t e1;
        int w;
        rst_n = 1'b0;
        in_valid = 1'b0;
        drive(mk(3'd0, 32'd0, 32'd0));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_result", 128'(result), 128'd0);
        chk("rst_vresult", 128'(vresult), 128'd0);
        chk("rst_flags", 128'({zero, negative, carry, overflow, eq, blt}), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back ADD then SUB at full throughput
        send_op(mk(3'd0, 32'hFFFF_FFFF, 32'd1), w);
        send_op(mk(3'd1, 32'd5, 32'd7), w);
        chk("b2b_no_stall", 128'(w), 128'd0);
        #1;
        chk("sub_result", 128'(result), 128'hFFFF_FFFE);
        chk("sub_neg_blt", 128'({negative, blt}), 128'b11);
        @(posedge clk);
        #1;

        // forwarding, immediate, broadcast of forwarded reg values
        t = mk(3'd0, 32'd3, 32'd1);
        t.afwd = 1'b1; t.fa = 32'd10; t.selb = 2'd1; t.imm = 32'h20; t.vas = 1'b0; t.vbs = 1'b0;
        send_op(t, w);
        #1;
        chk("fwd_imm_result", 128'(result), 128'h2A);
        chk("fwd_bcast_vres", 128'(vresult), {32'd11, 32'd11, 32'd11, 32'd11});
        t = mk(3'd0, 32'd0, 32'd1);
        t.vbs = 1'b0; t.av = {32'd40, 32'd30, 32'd20, 32'hFFFF_FFFF};
        send_op(t, w);
        #1;
        chk("bcast_b_vres", 128'(vresult), {32'd41, 32'd31, 32'd21, 32'd0});
        @(posedge clk);
        #1;

        // vector MUL with lane mask: 3 busy cycles then result
        t = mk(3'd7, 32'd6, 32'd9);
        t.av = {32'd5, 32'd4, 32'd3, 32'd2}; t.bv = {32'd7, 32'd7, 32'd7, 32'd7}; t.mask = 4'b1011;
        send_op(t, w);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("mul_busy", 128'({busy, in_ready, out_valid}), 128'b100);
        end
        @(negedge clk);
        chk("mul_out_valid", 128'(out_valid), 128'd1);
        chk("mul_vresult", 128'(vresult), {32'd35, 32'd0, 32'd21, 32'd14});
        chk("mul_scalar", 128'(result), 128'd54);
        @(posedge clk);
        #1;

        // backpressure: hold for 5 cycles with a second op queued
        rdy_mode = 2;
        t = mk(3'd4, 32'hA5A5_0000, 32'h0000_5A5A);
        e1 = model(t);
        send_op(t, w);
        t2 = mk(3'd0, 32'h7FFF_FFFF, 32'd1);
        drive(t2);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 128'({in_ready, out_valid}), 128'b01);
            chk("bp_result", 128'(result), 128'(e1.res));
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_op(t2, w);
        #1;
        chk("ovf_neg", 128'({overflow, negative}), 128'b11);
        send_op(mk(3'd5, 32'd1, 32'd33), w);
        #1;
        chk("sll_wrap", 128'(result), 128'd2);
        @(posedge clk);
        #1;

        // randomized traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) send_op(rand_op(), w);
        rdy_mode = 0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 128'(exp_q.size()), 128'd0);

        // reset in the middle of a MUL
        t = mk(3'd7, 32'd3, 32'd3);
        send_op(t, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_outputs", 128'({out_valid, busy}), 128'd0);
        chk("midrst_result", 128'(result), 128'd0);
        chk("midrst_vresult", 128'(vresult), 128'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_in_ready", 128'(in_ready), 128'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_no_output", 128'({out_valid, busy}), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
